dma_copy: RTL and testbench



---
 rtl/dma_pkg.sv | 33 +++
 rtl/dma_copy.sv | 157 +++++++++++++++
 tb/tb_dma_copy.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the dma_copy word-copy engine.
package dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } dma_state_e;

    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_ABORT = 1;

    localparam int unsigned STAT_BUSY  = 0;
    localparam int unsigned STAT_DONE  = 1;
    localparam int unsigned STAT_FAULT = 2;

    function automatic logic [31:0] apply_mask(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  mask);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dma_copy.sv
// Memory-to-memory word copy engine: responder port for programming,
// initiator port issuing one read then one write per word.
module dma_copy
    import dma_pkg::*;
#(
    parameter int unsigned LEN_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address_in,
    input  logic        sel_in,
    input  logic        read_in,
    output logic [31:0] read_value_out,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic        ready_out,
    output logic [31:0] m_address_out,
    output logic        m_read_out,
    output logic        m_write_out,
    input  logic [31:0] m_read_value_in,
    output logic [3:0]  m_write_mask_out,
    output logic [31:0] m_write_value_out,
    input  logic        m_ready_in,
    input  logic        m_fault_in,
    output logic        irq_out
);

    dma_state_e           state_q;
    logic [31:0]          src_q, dst_q, cur_src_q, cur_dst_q, data_q, m_addr_q;
    logic [LEN_WIDTH-1:0] len_q, rem_q;
    logic                 done_q, fault_q, abort_q, m_read_q, m_write_q;

    logic [1:0] reg_idx;
    logic       busy, start_req, abort_req, cfg_wr;
    logic       unused_addr;

    assign reg_idx     = address_in[3:2];
    assign busy        = (state_q != IDLE);
    assign cfg_wr      = sel_in && !busy;
    assign start_req   = sel_in && (reg_idx == REG_CTRL) && write_mask_in[0]
                         && write_value_in[CTRL_START];
    assign abort_req   = sel_in && (reg_idx == REG_CTRL) && write_mask_in[0]
                         && write_value_in[CTRL_ABORT];
    assign unused_addr = ^{address_in[31:4], address_in[1:0]};

    assign ready_out         = sel_in;
    assign irq_out           = done_q | fault_q;
    assign m_address_out     = m_addr_q;
    assign m_read_out        = m_read_q;
    assign m_write_out       = m_write_q;
    assign m_write_mask_out  = {4{m_write_q}};
    assign m_write_value_out = data_q;

    always_comb begin
        read_value_out = '0;
        if (sel_in && read_in) begin
            unique case (reg_idx)
                REG_SRC:  read_value_out = src_q;
                REG_DST:  read_value_out = dst_q;
                REG_LEN:  read_value_out = 32'(len_q);
                REG_CTRL: read_value_out = {29'b0, fault_q, done_q, busy};
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            cur_src_q <= '0;
            cur_dst_q <= '0;
            rem_q     <= '0;
            data_q    <= '0;
            m_addr_q  <= '0;
            done_q    <= 1'b0;
            fault_q   <= 1'b0;
            abort_q   <= 1'b0;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
        end else begin
            if (cfg_wr && reg_idx == REG_SRC) begin
                src_q <= apply_mask(src_q, write_value_in, write_mask_in) & ~32'd3;
            end
            if (cfg_wr && reg_idx == REG_DST) begin
                dst_q <= apply_mask(dst_q, write_value_in, write_mask_in) & ~32'd3;
            end
            if (cfg_wr && reg_idx == REG_LEN) begin
                len_q <= LEN_WIDTH'(apply_mask(32'(len_q), write_value_in, write_mask_in));
            end

            // Strobes are raised one cycle after the previous handshake, giving a turnaround gap.
            unique case (state_q)
                IDLE: begin
                    if (start_req) begin
                        done_q    <= (len_q == '0);
                        fault_q   <= 1'b0;
                        abort_q   <= 1'b0;
                        cur_src_q <= src_q;
                        cur_dst_q <= dst_q;
                        rem_q     <= len_q;
                        if (len_q != '0) begin
                            state_q  <= READ;
                            m_read_q <= 1'b1;
                            m_addr_q <= src_q;
                        end
                    end
                end
                READ: begin
                    if (abort_req) abort_q <= 1'b1;
                    if (!m_read_q) begin
                        m_read_q <= 1'b1;
                        m_addr_q <= cur_src_q;
                    end else if (m_ready_in) begin
                        m_read_q <= 1'b0;
                        if (m_fault_in) begin
                            fault_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            data_q  <= m_read_value_in;
                            state_q <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (abort_req) abort_q <= 1'b1;
                    if (!m_write_q) begin
                        m_write_q <= 1'b1;
                        m_addr_q  <= cur_dst_q;
                    end else if (m_ready_in) begin
                        m_write_q <= 1'b0;
                        if (m_fault_in) begin
                            fault_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            cur_src_q <= cur_src_q + 32'd4;
                            cur_dst_q <= cur_dst_q + 32'd4;
                            rem_q     <= rem_q - LEN_WIDTH'(1);
                            if (rem_q == LEN_WIDTH'(1)) begin
                                done_q  <= 1'b1;
                                state_q <= IDLE;
                            end else if (abort_q || abort_req) begin
                                abort_q <= 1'b0;
                                state_q <= IDLE;
                            end else begin
                                state_q <= READ;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_copy.sv
// Self-checking bench for dma_copy: RAM model with optional wait states and
// a transaction-level reference built from the programmed src/dst/len.
module tb_dma_copy;
    import dma_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address_in, read_value_out, write_value_in;
    logic        sel_in, read_in, ready_out;
    logic [3:0]  write_mask_in;
    logic [31:0] m_address_out, m_read_value_in, m_write_value_out;
    logic        m_read_out, m_write_out, m_ready_in, m_fault_in, irq_out;
    logic [3:0]  m_write_mask_out;

    always #5 clk = ~clk;

    dma_copy #(.LEN_WIDTH(16)) dut (
        .clk               (clk),
        .reset             (reset),
        .address_in        (address_in),
        .sel_in            (sel_in),
        .read_in           (read_in),
        .read_value_out    (read_value_out),
        .write_mask_in     (write_mask_in),
        .write_value_in    (write_value_in),
        .ready_out         (ready_out),
        .m_address_out     (m_address_out),
        .m_read_out        (m_read_out),
        .m_write_out       (m_write_out),
        .m_read_value_in   (m_read_value_in),
        .m_write_mask_out  (m_write_mask_out),
        .m_write_value_out (m_write_value_out),
        .m_ready_in        (m_ready_in),
        .m_fault_in        (m_fault_in),
        .irq_out           (irq_out)
    );

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic [31:0] mem  [0:255];
    logic [31:0] snap [0:255];
    txn_t        log_q[$];
    txn_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          wait_cnt = 0;
    int          strobe_seen = 0;
    bit          rand_wait = 0;
    bit          fault_en = 0;
    logic [31:0] fault_addr = '0;
    bit          hold_v = 0;
    logic [31:0] hold_addr, hold_data;
    logic        hold_r, hold_w;

    // RAM model: word index from address bits [9:2]
    assign m_ready_in      = (m_read_out | m_write_out) && (wait_cnt == 0);
    assign m_fault_in      = m_ready_in && fault_en && m_read_out && (m_address_out == fault_addr);
    assign m_read_value_in = mem[m_address_out[9:2]];

    always @(posedge clk) begin
        if (!reset && m_ready_in) begin
            if (m_write_out) begin
                mem[m_address_out[9:2]] = m_write_value_out;
                log_q.push_back({1'b1, m_address_out, m_write_value_out});
            end else begin
                log_q.push_back({1'b0, m_address_out, m_read_value_in});
            end
        end
    end

    always @(negedge clk) begin
        if (hold_v && !reset) begin
            checks++;
            if (m_address_out !== hold_addr || m_read_out !== hold_r || m_write_out !== hold_w
                || (hold_w && m_write_value_out !== hold_data)) begin
                errors++;
                $display("FAIL stable got a=%h r=%b w=%b d=%h exp a=%h r=%b w=%b d=%h",
                         m_address_out, m_read_out, m_write_out, m_write_value_out,
                         hold_addr, hold_r, hold_w, hold_data);
            end
        end
        if (m_read_out | m_write_out) strobe_seen++;
        if (!(m_read_out | m_write_out)) wait_cnt = rand_wait ? int'($urandom_range(0, 5)) : 0;
        else if (wait_cnt > 0) wait_cnt--;
        hold_v    = (m_read_out | m_write_out) && (wait_cnt != 0) && !reset;
        hold_addr = m_address_out;
        hold_data = m_write_value_out;
        hold_r    = m_read_out;
        hold_w    = m_write_out;
    end

    task automatic bus_write(input logic [1:0] idx, input logic [31:0] v, input logic [3:0] mask);
        @(negedge clk);
        sel_in = 1'b1; read_in = 1'b0; address_in = {28'h0004000, idx, 2'b00};
        write_mask_in = mask; write_value_in = v;
        @(posedge clk);
        #1;
        sel_in = 1'b0; write_mask_in = 4'h0;
    endtask

    task automatic bus_read(input logic [1:0] idx, output logic [31:0] v);
        @(negedge clk);
        sel_in = 1'b1; read_in = 1'b1; address_in = {28'h0004000, idx, 2'b00};
        write_mask_in = 4'h0;
        #1;
        v = read_value_out;
        sel_in = 1'b0; read_in = 1'b0;
    endtask

    task automatic wait_idle(input int max, output bit ok);
        logic [31:0] s;
        ok = 0;
        for (int i = 0; i < max; i++) begin
            bus_read(REG_CTRL, s);
            if (!s[STAT_BUSY]) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic setup_and_start(input logic [31:0] src, input logic [31:0] dst,
                                   input logic [31:0] len);
        bus_write(REG_SRC, src, 4'hF);
        bus_write(REG_DST, dst, 4'hF);
        bus_write(REG_LEN, len, 4'hF);
        snap = mem;
        log_q.delete();
        bus_write(REG_CTRL, 32'h1, 4'h1);
    endtask

    // Reference: word i reads src+4i then writes that source word to dst+4i.
    function automatic void build_exp(input logic [31:0] src, input logic [31:0] dst,
                                      input int nwords, input bit last_read_faults);
        logic [31:0] a, d;
        exp_q.delete();
        for (int i = 0; i < nwords; i++) begin
            a = src + 32'(4 * i);
            d = dst + 32'(4 * i);
            exp_q.push_back({1'b0, a, snap[a[9:2]]});
            if (last_read_faults && i == nwords - 1) break;
            exp_q.push_back({1'b1, d, snap[a[9:2]]});
        end
    endfunction

    task automatic test_reset();
        logic [31:0] v;
        checks++;
        if ({m_read_out, m_write_out, m_write_mask_out, irq_out} !== 7'b0
            || m_address_out !== 32'h0 || m_write_value_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got r=%b w=%b m=%h irq=%b a=%h d=%h exp all 0",
                     m_read_out, m_write_out, m_write_mask_out, irq_out, m_address_out,
                     m_write_value_out);
        end
        checks++;
        if (read_value_out !== 32'h0 || ready_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_bus got rv=%h rdy=%b exp 0/0", read_value_out, ready_out);
        end
        for (int i = 0; i < 4; i++) begin
            bus_read(2'(i), v);
            checks++;
            if (v !== 32'h0) begin
                errors++;
                $display("FAIL reset_reg%0d got=%h exp=0", i, v);
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] v;
        bit ok;
        rand_wait = 0; fault_en = 0;
        setup_and_start(32'h1000_0000, 32'h1000_0100, 3);
        checks++;
        if (m_read_out !== 1'b1 || m_address_out !== 32'h1000_0000) begin
            errors++;
            $display("FAIL basic_first_read got r=%b a=%h exp r=1 a=10000000", m_read_out,
                     m_address_out);
        end
        bus_read(REG_CTRL, v);
        checks++;
        if (v !== 32'h1) begin
            errors++;
            $display("FAIL basic_busy got=%h exp=1", v);
        end
        wait_idle(200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_timeout got busy exp idle");
        end
        build_exp(32'h1000_0000, 32'h1000_0100, 3, 0);
        checks++;
        if (log_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL basic_count got=%0d exp=%0d", log_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (log_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL basic_txn%0d got=%h exp=%h", i, log_q[i], exp_q[i]);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem[64 + i] !== snap[i]) begin
                errors++;
                $display("FAIL basic_dst%0d got=%h exp=%h", i, mem[64 + i], snap[i]);
            end
        end
        bus_read(REG_CTRL, v);
        checks++;
        if (v !== 32'h2 || irq_out !== 1'b1) begin
            errors++;
            $display("FAIL basic_status got=%h irq=%b exp=2 irq=1", v, irq_out);
        end
        // low two lanes only; bits [1:0] always read back as zero
        bus_write(REG_SRC, 32'hABCD_1237, 4'b0011);
        bus_read(REG_SRC, v);
        checks++;
        if (v !== 32'h1000_1234) begin
            errors++;
            $display("FAIL basic_src_mask got=%h exp=10001234", v);
        end
    endtask

    task automatic test_len_zero();
        logic [31:0] v;
        strobe_seen = 0;
        bus_write(REG_CTRL, 32'h0, 4'hF);
        bus_write(REG_LEN, 32'h0, 4'hF);
        bus_write(REG_CTRL, 32'h1, 4'h1);
        bus_read(REG_CTRL, v);
        checks++;
        if (v !== 32'h2 || irq_out !== 1'b1) begin
            errors++;
            $display("FAIL len0_status got=%h irq=%b exp=2 irq=1", v, irq_out);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (strobe_seen != 0) begin
            errors++;
            $display("FAIL len0_traffic got=%0d strobe cycles exp=0", strobe_seen);
        end
    endtask

    task automatic test_fault();
        logic [31:0] v;
        bit ok;
        rand_wait = 0; fault_en = 1; fault_addr = 32'h1000_0048;
        setup_and_start(32'h1000_0040, 32'h1000_0200, 4);
        wait_idle(200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL fault_timeout got busy exp idle");
        end
        repeat (3) @(negedge clk);
        build_exp(32'h1000_0040, 32'h1000_0200, 3, 1);
        checks++;
        if (log_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL fault_count got=%0d exp=%0d", log_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (log_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL fault_txn%0d got=%h exp=%h", i, log_q[i], exp_q[i]);
                end
            end
        end
        bus_read(REG_CTRL, v);
        checks++;
        if (v !== 32'h4 || irq_out !== 1'b1) begin
            errors++;
            $display("FAIL fault_status got=%h irq=%b exp=4 irq=1", v, irq_out);
        end
        fault_en = 0;
        setup_and_start(32'h1000_0040, 32'h1000_0200, 1);
        bus_read(REG_CTRL, v);
        checks++;
        if (v !== 32'h1) begin
            errors++;
            $display("FAIL fault_restart got=%h exp=1", v);
        end
        wait_idle(200, ok);
        bus_read(REG_CTRL, v);
        checks++;
        if (!ok || v !== 32'h2) begin
            errors++;
            $display("FAIL fault_cleared got=%h ok=%0d exp=2", v, ok);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] src, dst, v;
        int n;
        bit ok;
        rand_wait = 1; fault_en = 0;
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 256; i++) mem[i] = $urandom;
            src = 32'h1000_0000 + 32'(4 * $urandom_range(0, 31));
            dst = 32'h1000_0200 + 32'(4 * $urandom_range(0, 31));
            n   = int'($urandom_range(1, 8));
            setup_and_start(src, dst, 32'(n));
            wait_idle(2000, ok);
            build_exp(src, dst, n, 0);
            checks++;
            if (!ok || log_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL wait%0d_count got=%0d ok=%0d exp=%0d", it, log_q.size(), ok,
                         exp_q.size());
            end else begin
                foreach (exp_q[i]) begin
                    checks++;
                    if (log_q[i] !== exp_q[i]) begin
                        errors++;
                        $display("FAIL wait%0d_txn%0d got=%h exp=%h", it, i, log_q[i], exp_q[i]);
                    end
                end
            end
            bus_read(REG_CTRL, v);
            checks++;
            if (v !== 32'h2) begin
                errors++;
                $display("FAIL wait%0d_status got=%h exp=2", it, v);
            end
        end
        rand_wait = 0;
    endtask

    task automatic test_abort();
        logic [31:0] v;
        bit found, ok;
        rand_wait = 0; fault_en = 0;
        setup_and_start(32'h1000_0000, 32'h1000_0300, 4);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (m_read_out && m_address_out == 32'h1000_0004) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL abort_no_read1 got none exp read at 10000004");
        end
        sel_in = 1'b1; read_in = 1'b0; address_in = {28'h0004000, REG_CTRL, 2'b00};
        write_mask_in = 4'h1; write_value_in = 32'h2;
        @(posedge clk);
        #1;
        sel_in = 1'b0; write_mask_in = 4'h0;
        bus_write(REG_LEN, 32'd99, 4'hF);
        wait_idle(200, ok);
        repeat (3) @(negedge clk);
        build_exp(32'h1000_0000, 32'h1000_0300, 2, 0);
        checks++;
        if (!ok || log_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL abort_count got=%0d ok=%0d exp=%0d", log_q.size(), ok, exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (log_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL abort_txn%0d got=%h exp=%h", i, log_q[i], exp_q[i]);
                end
            end
        end
        bus_read(REG_CTRL, v);
        checks++;
        if (v !== 32'h0 || irq_out !== 1'b0) begin
            errors++;
            $display("FAIL abort_status got=%h irq=%b exp=0 irq=0", v, irq_out);
        end
        bus_read(REG_LEN, v);
        checks++;
        if (v !== 32'd4) begin
            errors++;
            $display("FAIL abort_len got=%0d exp=4", v);
        end
    endtask

    task automatic test_wrap_and_reset();
        logic [31:0] v;
        bit found, ok;
        rand_wait = 0; fault_en = 0;
        setup_and_start(32'hFFFF_FFFC, 32'h1000_0100, 2);
        wait_idle(200, ok);
        build_exp(32'hFFFF_FFFC, 32'h1000_0100, 2, 0);
        checks++;
        if (!ok || log_q.size() != 4 || log_q[2].addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_second_read got n=%0d a=%h exp n=4 a=00000000", log_q.size(),
                     (log_q.size() > 2) ? log_q[2].addr : 32'hX);
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (log_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL wrap_txn%0d got=%h exp=%h", i, log_q[i], exp_q[i]);
                end
            end
        end
        setup_and_start(32'hFFFF_FFFC, 32'h1000_0100, 2);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (m_write_out) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rst_no_write got none exp write strobe");
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (m_read_out !== 1'b0 || m_write_out !== 1'b0 || m_write_mask_out !== 4'h0
            || irq_out !== 1'b0) begin
            errors++;
            $display("FAIL rst_strobes got r=%b w=%b m=%h irq=%b exp all 0", m_read_out,
                     m_write_out, m_write_mask_out, irq_out);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        bus_read(REG_CTRL, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL rst_status got=%h exp=0", v);
        end
        bus_read(REG_SRC, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL rst_src got=%h exp=0", v);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        sel_in = 1'b0; read_in = 1'b0; address_in = '0;
        write_mask_in = '0; write_value_in = '0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_basic();
        test_len_zero();
        test_fault();
        test_wait_states();
        test_abort();
        test_wrap_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
